branch_predictor_table_ctrl: RTL and testbench

Controller sitting between the fetch-stage branch predictor logic and one branch_predictor_ram instance (one read port, one write port). It runs a table-clear sequence after reset and on flush requests. It buffers training updates in a small queue and arbitrates the write port between clearing and updates. It also forwards same-cycle writes to lookups, so fetch never sees stale read-first data.

---
 rtl/branch_predictor_table_ctrl.sv | 134 +++++++++++++
 tb/tb_branch_predictor_table_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table_ctrl.sv
// Table controller for a branch predictor RAM: clears the table after reset/flush,
// buffers training updates, arbitrates the write port and forwards writes to lookups.
module branch_predictor_table_ctrl #(
   parameter int C_DATA_WIDTH       = 20,
   parameter int C_DEPTH            = 512,
   parameter int UPDATE_QUEUE_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   output logic                        init_done,
   input  logic                        lookup_valid,
   input  logic [$clog2(C_DEPTH)-1:0]  lookup_addr,
   output logic                        lookup_data_valid,
   output logic [C_DATA_WIDTH-1:0]     lookup_data,
   input  logic                        update_valid,
   input  logic [$clog2(C_DEPTH)-1:0]  update_addr,
   input  logic [C_DATA_WIDTH-1:0]     update_data,
   output logic                        update_ready,
   output logic [$clog2(C_DEPTH)-1:0]  ram_write_addr,
   output logic                        ram_write_en,
   output logic [C_DATA_WIDTH-1:0]     ram_write_data,
   output logic [$clog2(C_DEPTH)-1:0]  ram_read_addr,
   output logic                        ram_read_en,
   input  logic [C_DATA_WIDTH-1:0]     ram_read_data
);
   localparam int AW = $clog2(C_DEPTH);
   localparam int QW = $clog2(UPDATE_QUEUE_DEPTH);
   localparam int CW = QW + 1;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
   logic [QW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_base;
   logic [CW-1:0]           q_count_q, q_count_d;
   logic [AW-1:0]           q_addr_q [UPDATE_QUEUE_DEPTH];
   logic [AW-1:0]           q_addr_d [UPDATE_QUEUE_DEPTH];
   logic [C_DATA_WIDTH-1:0] q_data_q [UPDATE_QUEUE_DEPTH];
   logic [C_DATA_WIDTH-1:0] q_data_d [UPDATE_QUEUE_DEPTH];
   logic                    lookup_vld_q, lookup_vld_d;
   logic                    fwd_hit_q, fwd_hit_d;
   logic [C_DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

   logic in_run, flush_run, push, pop, lookup_acc;

   assign in_run       = (state_q == S_RUN);
   assign flush_run    = in_run & flush;
   assign update_ready = (q_count_q != CW'(UPDATE_QUEUE_DEPTH));
   assign push         = update_valid & update_ready;
   // The queue head is dropped, not written, in the flush cycle: it would be wiped anyway.
   assign pop          = in_run & ~flush & (q_count_q != '0);
   assign lookup_acc   = lookup_valid & in_run & ~rst;

   assign init_done         = in_run & ~rst;
   assign ram_read_en       = lookup_acc;
   assign ram_read_addr     = lookup_addr;
   assign lookup_data_valid = lookup_vld_q;
   assign lookup_data       = fwd_hit_q ? fwd_data_q : ram_read_data;

   always_comb begin
      ram_write_en   = 1'b0;
      ram_write_addr = clr_cnt_q;
      ram_write_data = '0;
      if (!in_run) begin
         ram_write_en = ~rst;
      end else if (pop) begin
         ram_write_en   = ~rst;
         ram_write_addr = q_addr_q[rd_ptr_q];
         ram_write_data = q_data_q[rd_ptr_q];
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (!in_run) begin
         if (flush) begin
            clr_cnt_d = '0;
         end else if (clr_cnt_q == AW'(C_DEPTH - 1)) begin
            state_d   = S_RUN;
            clr_cnt_d = '0;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end else if (flush) begin
         state_d   = S_CLEAR;
         clr_cnt_d = '0;
      end
   end

   // A flush in RUN empties the queue but keeps the update accepted alongside it.
   always_comb begin
      q_addr_d = q_addr_q;
      q_data_d = q_data_q;
      wr_base  = flush_run ? '0 : wr_ptr_q;
      if (push) begin
         q_addr_d[wr_base] = update_addr;
         q_data_d[wr_base] = update_data;
      end
      wr_ptr_d  = wr_base + QW'(push);
      rd_ptr_d  = flush_run ? '0 : rd_ptr_q + QW'(pop);
      q_count_d = flush_run ? CW'(push) : q_count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      lookup_vld_d = lookup_acc;
      fwd_hit_d    = lookup_acc & ram_write_en & (ram_write_addr == lookup_addr);
      fwd_data_d   = ram_write_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_CLEAR;
         clr_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         q_count_q    <= '0;
         lookup_vld_q <= 1'b0;
         fwd_hit_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         q_count_q    <= q_count_d;
         lookup_vld_q <= lookup_vld_d;
         fwd_hit_q    <= fwd_hit_d;
      end
      fwd_data_q <= fwd_data_d;
      q_addr_q   <= q_addr_d;
      q_data_q   <= q_data_d;
   end
endmodule

// File: tb/tb_branch_predictor_table_ctrl.sv
// Bench for branch_predictor_table_ctrl (8-entry table, 2-entry queue) with a
// read-first RAM model and a table-level reference model for random traffic.
module tb_branch_predictor_table_ctrl;
   localparam int DW = 20;
   localparam int DEPTH = 8;
   localparam int QD = 2;
   localparam int AW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, init_done, lookup_valid, lookup_data_valid;
   logic update_valid, update_ready, ram_write_en, ram_read_en;
   logic [AW-1:0] lookup_addr, update_addr, ram_write_addr, ram_read_addr;
   logic [DW-1:0] lookup_data, update_data, ram_write_data, ram_read_data;

   branch_predictor_table_ctrl #(.C_DATA_WIDTH(DW), .C_DEPTH(DEPTH), .UPDATE_QUEUE_DEPTH(QD)) dut (
      .clk(clk), .rst(rst), .flush(flush), .init_done(init_done),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
      .lookup_data_valid(lookup_data_valid), .lookup_data(lookup_data),
      .update_valid(update_valid), .update_addr(update_addr), .update_data(update_data),
      .update_ready(update_ready), .ram_write_addr(ram_write_addr), .ram_write_en(ram_write_en),
      .ram_write_data(ram_write_data), .ram_read_addr(ram_read_addr), .ram_read_en(ram_read_en),
      .ram_read_data(ram_read_data));

   // Registered, read-first RAM.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (ram_read_en) ram_read_data <= ram[ram_read_addr];
      if (ram_write_en) ram[ram_write_addr] <= ram_write_data;
   end

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } upd_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; lookup_valid = 0; lookup_addr = '0;
      update_valid = 0; update_addr = '0; update_data = '0;
   endtask

   // Returns in the window of clear cycle 0 (first cycle with rst low).
   task automatic do_reset();
      rst = 1; idle();
      repeat (2) tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle(); lookup_valid = 1;
      repeat (2) tick();
      #1;
      n_cmp++;
      if ({ram_write_en, ram_read_en, init_done, lookup_data_valid} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs got=%b exp=0000",
            {ram_write_en, ram_read_en, init_done, lookup_data_valid});
      end
      rst = 0;
      for (int i = 0; i < DEPTH; i++) begin
         lookup_valid = 1; lookup_addr = AW'($urandom_range(0, DEPTH-1));
         #1;
         n_cmp++;
         if ({ram_write_en, ram_write_addr, ram_write_data, ram_read_en, init_done} !==
             {1'b1, AW'(i), DW'(0), 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL clear_write[%0d] en=%b addr=%0d data=%h rd=%b init=%b exp en=1 addr=%0d data=0 rd=0 init=0",
               i, ram_write_en, ram_write_addr, ram_write_data, ram_read_en, init_done, i);
         end
         tick();
         n_cmp++;
         if (lookup_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_lookup_valid[%0d] got=%b exp=0", i, lookup_data_valid);
         end
      end
      lookup_valid = 0;
      n_cmp++;
      if (init_done !== 1'b1) begin
         n_fail++; $display("FAIL init_done_after_clear got=%b exp=1", init_done);
      end
   endtask

   // Assumes RUN with an empty queue.
   task automatic test_forward();
      update_valid = 1; update_addr = 3; update_data = 20'h5A5A5;
      tick();
      update_valid = 0; lookup_valid = 1; lookup_addr = 3;
      #1;
      n_cmp++;
      if ({ram_write_en, ram_write_addr, ram_write_data} !== {1'b1, 3'd3, 20'h5A5A5}) begin
         n_fail++; $display("FAIL fwd_write en=%b addr=%0d data=%h exp 1/3/5a5a5",
            ram_write_en, ram_write_addr, ram_write_data);
      end
      tick();
      lookup_valid = 0;
      n_cmp++;
      if ({lookup_data_valid, lookup_data} !== {1'b1, 20'h5A5A5}) begin
         n_fail++; $display("FAIL fwd_lookup valid=%b data=%h exp 1/5a5a5", lookup_data_valid, lookup_data);
      end
      tick();
      lookup_valid = 1; lookup_addr = 3;
      tick();
      lookup_valid = 0;
      n_cmp++;
      if ({lookup_data_valid, lookup_data} !== {1'b1, 20'h5A5A5}) begin
         n_fail++; $display("FAIL ram_lookup valid=%b data=%h exp 1/5a5a5", lookup_data_valid, lookup_data);
      end
   endtask

   task automatic test_clear_flood();
      upd_t acc[$];
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         update_valid = 1; update_addr = AW'($urandom_range(0, DEPTH-1)); update_data = DW'($urandom());
         #1;
         if (update_ready) acc.push_back('{update_addr, update_data});
         tick();
      end
      update_valid = 0;
      n_cmp++;
      if (acc.size() != QD) begin
         n_fail++; $display("FAIL flood_accepts got=%0d exp=%0d", acc.size(), QD);
      end
      if (acc.size() == QD) begin
         for (int k = 0; k < QD; k++) begin
            #1;
            n_cmp++;
            if ({ram_write_en, ram_write_addr, ram_write_data} !== {1'b1, acc[k].a, acc[k].d}) begin
               n_fail++; $display("FAIL flood_drain[%0d] en=%b addr=%0d data=%h exp 1/%0d/%h",
                  k, ram_write_en, ram_write_addr, ram_write_data, acc[k].a, acc[k].d);
            end
            tick();
         end
      end
      #1;
      n_cmp++;
      if ({ram_write_en, update_ready} !== 2'b01) begin
         n_fail++; $display("FAIL flood_after en=%b ready=%b exp en=0 ready=1", ram_write_en, update_ready);
      end
   endtask

   task automatic test_flush_run();
      logic [DW-1:0] exp_v [3];
      logic [AW-1:0] la [3];
      exp_v[0] = '0; exp_v[1] = '0; exp_v[2] = 20'h33333;
      la[0] = 1; la[1] = 2; la[2] = 4;
      do_reset();
      update_valid = 1; update_addr = 1; update_data = 20'h11111; tick();
      update_addr = 2; update_data = 20'h22222; tick();
      update_valid = 0;
      repeat (7) tick();
      // Cycle 9: one update still queued, flush plus a fresh update.
      flush = 1; update_valid = 1; update_addr = 4; update_data = 20'h33333;
      #1;
      n_cmp++;
      if (update_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_ready got=%b exp=1", update_ready);
      end
      tick();
      flush = 0; update_valid = 0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_cmp++;
         if ({ram_write_en, ram_write_addr, ram_write_data, init_done} !== {1'b1, AW'(i), DW'(0), 1'b0}) begin
            n_fail++; $display("FAIL flush_clear[%0d] en=%b addr=%0d data=%h init=%b exp 1/%0d/0/0",
               i, ram_write_en, ram_write_addr, ram_write_data, init_done, i);
         end
         tick();
      end
      #1;
      n_cmp++;
      if ({ram_write_en, ram_write_addr, ram_write_data, init_done} !== {1'b1, 3'd4, 20'h33333, 1'b1}) begin
         n_fail++; $display("FAIL flush_kept en=%b addr=%0d data=%h init=%b exp 1/4/33333/1",
            ram_write_en, ram_write_addr, ram_write_data, init_done);
      end
      tick();
      #1;
      n_cmp++;
      if (ram_write_en !== 1'b0) begin
         n_fail++; $display("FAIL flush_discard en=%b exp=0", ram_write_en);
      end
      for (int k = 0; k < 3; k++) begin
         lookup_valid = 1; lookup_addr = la[k];
         tick();
         lookup_valid = 0;
         n_cmp++;
         if ({lookup_data_valid, lookup_data} !== {1'b1, exp_v[k]}) begin
            n_fail++; $display("FAIL flush_lookup[%0d] valid=%b data=%h exp 1/%h",
               la[k], lookup_data_valid, lookup_data, exp_v[k]);
         end
      end
   endtask

   task automatic test_flush_clear();
      do_reset();
      repeat (5) tick();
      flush = 1;
      #1;
      n_cmp++;
      if ({ram_write_en, ram_write_addr} !== {1'b1, 3'd5}) begin
         n_fail++; $display("FAIL flush_at5 en=%b addr=%0d exp 1/5", ram_write_en, ram_write_addr);
      end
      tick();
      flush = 0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_cmp++;
         if ({ram_write_en, ram_write_addr, init_done} !== {1'b1, AW'(i), 1'b0}) begin
            n_fail++; $display("FAIL reclear[%0d] en=%b addr=%0d init=%b exp 1/%0d/0",
               i, ram_write_en, ram_write_addr, init_done, i);
         end
         tick();
      end
      n_cmp++;
      if (init_done !== 1'b1) begin
         n_fail++; $display("FAIL reclear_done got=%b exp=1", init_done);
      end
   endtask

   task automatic test_rst_run();
      do_reset();
      update_valid = 1; update_addr = 5; update_data = DW'($urandom()); tick();
      update_addr = 6; update_data = DW'($urandom()); tick();
      update_valid = 0;
      repeat (6) tick();
      rst = 1;
      #1;
      n_cmp++;
      if ({ram_write_en, init_done} !== 2'b00) begin
         n_fail++; $display("FAIL rst_run_gate en=%b init=%b exp 0/0", ram_write_en, init_done);
      end
      tick();
      rst = 0;
      #1;
      n_cmp++;
      if ({init_done, update_ready, ram_write_en, ram_write_addr, ram_write_data} !==
          {1'b0, 1'b1, 1'b1, 3'd0, DW'(0)}) begin
         n_fail++; $display("FAIL rst_run_restart init=%b ready=%b en=%b addr=%0d data=%h exp 0/1/1/0/0",
            init_done, update_ready, ram_write_en, ram_write_addr, ram_write_data);
      end
      repeat (DEPTH) tick();
      #1;
      n_cmp++;
      if ({init_done, ram_write_en} !== 2'b10) begin
         n_fail++; $display("FAIL rst_run_empty init=%b en=%b exp 1/0", init_done, ram_write_en);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] tbl [DEPTH];
      upd_t pend[$];
      logic exp_lv;
      logic [DW-1:0] exp_ld;
      do_reset();
      repeat (DEPTH) tick();
      for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
      exp_lv = 0; exp_ld = '0;
      for (int c = 0; c < 300; c++) begin
         n_cmp++;
         if (lookup_data_valid !== exp_lv || (exp_lv && lookup_data !== exp_ld)) begin
            n_fail++; $display("FAIL rand_lookup[%0d] valid=%b data=%h exp %b/%h",
               c, lookup_data_valid, lookup_data, exp_lv, exp_ld);
         end
         update_valid = ($urandom_range(0, 1) == 1);
         update_addr  = AW'($urandom_range(0, DEPTH-1));
         update_data  = DW'($urandom());
         lookup_valid = ($urandom_range(0, 9) < 6);
         lookup_addr  = AW'($urandom_range(0, DEPTH-1));
         #1;
         n_cmp++;
         if (update_ready !== (pend.size() < QD)) begin
            n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, update_ready, pend.size() < QD);
         end
         // One buffered update lands per RUN cycle; a lookup sees that cycle's write.
         if (pend.size() > 0) begin
            tbl[pend[0].a] = pend[0].d;
            void'(pend.pop_front());
         end
         exp_lv = lookup_valid;
         exp_ld = tbl[lookup_addr];
         if (update_valid && update_ready) pend.push_back('{update_addr, update_data});
         tick();
      end
      idle();
      n_cmp++;
      if (lookup_data_valid !== exp_lv || (exp_lv && lookup_data !== exp_ld)) begin
         n_fail++; $display("FAIL rand_lookup_last valid=%b data=%h exp %b/%h",
            lookup_data_valid, lookup_data, exp_lv, exp_ld);
      end
   endtask

   initial begin
      rst = 1; idle();
      test_reset();
      test_forward();
      test_clear_flood();
      test_flush_run();
      test_flush_clear();
      test_rst_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
